// File: rtl/clk_tick_gen_pkg.sv
// Shared constants and helpers for the programmable clock-tick generator.
// Divisor presets assume a 100 MHz system clock.
package clk_tick_gen_pkg;

    localparam int unsigned DEF_DIV_1KHZ = 100000;
    localparam int unsigned DIV_1HZ      = 100000000;
    localparam int unsigned DIV_60HZ     = 1666667;
    localparam int          W_DEFAULT    = 28;

    // Widest divisor the helper supports; channel widths must not exceed it.
    localparam int          W_MAX        = 63;

    // Number of high cycles per period, ceil(D/2), computed one bit wider than D
    // so that the all-ones divisor does not wrap to zero.
    function automatic logic [W_MAX:0] half_hi(input logic [W_MAX-1:0] d);
        return ({1'b0, d} + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, active and shadow divisor, registered div_clk/tick.
// CLK_TICK_GEN_SYNC_EN adds a sync input that phase-aligns the channel.
module clk_tick_chan
    import clk_tick_gen_pkg::*;
#(
    parameter int          W       = W_DEFAULT,
    parameter int unsigned DEF_DIV = DEF_DIV_1KHZ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
`ifdef CLK_TICK_GEN_SYNC_EN
    input  logic         sync,
`endif
    input  logic         wr,
    input  logic [W-1:0] wr_val,
    output logic         pending,
    output logic         div_clk,
    output logic         tick
);

    localparam logic [W-1:0] RST_DIV = W'(DEF_DIV);

    logic [W-1:0] cnt;
    logic [W-1:0] d;
    logic [W-1:0] shadow;
    logic [W-1:0] next_d;
    logic [W:0]   half;
    logic         idle;
    logic         wrap;
    logic         apply;
    logic         align;

`ifdef CLK_TICK_GEN_SYNC_EN
    assign align = sync;
`else
    assign align = 1'b0;
`endif

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        half   = (W+1)'(half_hi(W_MAX'(d)));
        idle   = !en || (d == '0);
        wrap   = (d != '0) && (cnt == d - W'(1));
        apply  = pending && (idle || align || wrap);
        next_d = apply ? shadow : d;
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            d       <= RST_DIV;
            shadow  <= RST_DIV;
            pending <= 1'b0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // A write on the apply edge lands in the shadow after the old shadow is consumed.
            if (wr) begin
                shadow  <= wr_val;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            d <= next_d;

            if (idle) begin
                cnt     <= '0;
                div_clk <= 1'b0;
                tick    <= 1'b0;
            end else if (align) begin
                cnt     <= '0;
                div_clk <= (next_d != '0);
                tick    <= 1'b0;
            end else begin
                div_clk <= ({1'b0, cnt} < half);
                tick    <= wrap;
                cnt     <= wrap ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock divider / tick generator with glitch-free divisor updates.
// Define CLK_TICK_GEN_SYNC_EN to add a global sync input that phase-aligns all channels.
module clk_tick_gen
    import clk_tick_gen_pkg::*;
#(
    parameter  int          CH      = 4,
    parameter  int          W       = W_DEFAULT,
    parameter  int unsigned DEF_DIV = DEF_DIV_1KHZ,
    localparam int          SW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] en,
`ifdef CLK_TICK_GEN_SYNC_EN
    input  logic          sync,
`endif
    input  logic          div_wr,
    input  logic [SW-1:0] div_sel,
    input  logic [W-1:0]  div_val,
    output logic [CH-1:0] div_pending,
    output logic [CH-1:0] div_clk,
    output logic [CH-1:0] tick
);

    logic [CH-1:0] wr_vec;

    // Selects at or beyond CH match no channel, so such writes are dropped.
    always_comb begin
        wr_vec = '0;
        for (int c = 0; c < CH; c++) begin
            wr_vec[c] = div_wr && (int'(div_sel) == c);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        clk_tick_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[c]),
`ifdef CLK_TICK_GEN_SYNC_EN
            .sync    (sync),
`endif
            .wr      (wr_vec[c]),
            .wr_val  (div_val),
            .pending (div_pending[c]),
            .div_clk (div_clk[c]),
            .tick    (tick[c])
        );
    end

endmodule
